// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | pll_lock_supervisor                                                    |
// | Sequences PLL reset, qualifies lock and releases the core reset.       |
// | Optional macro: PLL_LOCK_LOSS_COUNT_EN (saturating lock-loss counter). |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 4096,
    parameter int LOCK_TIMEOUT_CYCLES = 742500,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked_async,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       pll_ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int c_MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                               RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                               c_MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int c_CW      = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CW-1:0] c_RST_LAST = c_CW'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_STB_LAST = c_CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      c_MAX_RETRY = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              w_locked_s;
    logic [c_CW-1:0]   r_cnt;
    logic [3:0]        r_retry;
    logic              w_retry_inc;
    logic              w_retry_clr;
    logic              w_cnt_run;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked_async;
            r_sync2 <= r_sync1;
        end
    end

    assign w_locked_s = r_sync2;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RESET_PLL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority inside each state encodes the simultaneous-event rules:
    // lock level is always examined before counters or relock requests.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == c_TMO_LAST) begin
                    if (r_retry == c_MAX_RETRY) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == c_STB_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_locked_s || relock_req) begin
                    w_retry_clr = 1'b1;
                    w_state_nxt = S_RESET_PLL;
                end
            end
            S_FAIL: begin
                if (relock_req) begin
                    w_retry_clr = 1'b1;
                    w_state_nxt = S_RESET_PLL;
                end
            end
            default: begin
                w_state_nxt = S_RESET_PLL;
            end
        endcase
    end

    assign w_cnt_run = (r_state == S_RESET_PLL) || (r_state == S_WAIT_LOCK) ||
                       (r_state == S_STABLE);

    // Shared cycle counter restarts from zero on every state change
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_retry <= 4'd0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_retry_clr) begin
                r_retry <= 4'd0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 4'd1;
            end
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_evt;

    assign w_loss_evt = (r_state == S_RUN) && !w_locked_s;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`else
    assign lock_loss_count = 8'd0;
`endif

    assign pll_rst      = (r_state == S_RESET_PLL) || (r_state == S_FAIL);
    assign core_reset_n = (r_state == S_RUN);
    assign pll_ready    = (r_state == S_RUN);
    assign fail         = (r_state == S_FAIL);
    assign retry_count  = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pll_lock_supervisor                                                 |
// | Self-checking bench: vector table, directed corners, random vs model.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pll_lock_supervisor;

    localparam int RST_P = 4;
    localparam int STB   = 8;
    localparam int TMO   = 32;
    localparam int MAXR  = 2;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked_async;
    logic       relock_req;
    logic       pll_rst;
    logic       core_reset_n;
    logic       pll_ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RST_P),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk_74a          (clk_74a),
        .reset_n          (reset_n),
        .pll_locked_async (pll_locked_async),
        .relock_req       (relock_req),
        .pll_rst          (pll_rst),
        .core_reset_n     (core_reset_n),
        .pll_ready        (pll_ready),
        .fail             (fail),
        .retry_count      (retry_count),
        .lock_loss_count  (lock_loss_count)
    );

    always #5 clk_74a = ~clk_74a;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endfunction

    // Reference model: phase plus cycles-elapsed-in-phase, lock seen two edges late
    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    int m_phase;
    int m_t;
    int m_retry;
    int m_loss;
    bit m_h1;
    bit m_h2;

    function automatic void model_reset();
        m_phase = P_RST;
        m_t     = 0;
        m_retry = 0;
        m_loss  = 0;
        m_h1    = 1'b0;
        m_h2    = 1'b0;
    endfunction

    function automatic void model_step(input bit a, input bit rq);
        bit ls;
        int nxt;
        ls   = m_h2;
        m_h2 = m_h1;
        m_h1 = a;
        nxt  = m_phase;
        case (m_phase)
            P_RST:  if (m_t + 1 == RST_P) nxt = P_WAIT;
            P_WAIT: begin
                if (ls) nxt = P_STB;
                else if (m_t + 1 == TMO) begin
                    if (m_retry == MAXR) nxt = P_FAIL;
                    else begin
                        m_retry = m_retry + 1;
                        nxt = P_RST;
                    end
                end
            end
            P_STB:  begin
                if (!ls) nxt = P_WAIT;
                else if (m_t + 1 == STB) nxt = P_RUN;
            end
            P_RUN:  begin
                if (!ls) begin
                    nxt = P_RST;
                    m_retry = 0;
                    if (LOSS_EN != 0 && m_loss < 255) m_loss = m_loss + 1;
                end else if (rq) begin
                    nxt = P_RST;
                    m_retry = 0;
                end
            end
            P_FAIL: begin
                if (rq) begin
                    nxt = P_RST;
                    m_retry = 0;
                end
            end
            default: nxt = P_RST;
        endcase
        m_t     = (nxt != m_phase) ? 0 : m_t + 1;
        m_phase = nxt;
    endfunction

    function automatic void check_outputs(input string tag);
        chk({tag, ".pll_rst"},  32'(pll_rst),      32'((m_phase == P_RST) || (m_phase == P_FAIL)));
        chk({tag, ".core_rn"},  32'(core_reset_n), 32'(m_phase == P_RUN));
        chk({tag, ".ready"},    32'(pll_ready),    32'(m_phase == P_RUN));
        chk({tag, ".fail"},     32'(fail),         32'(m_phase == P_FAIL));
        chk({tag, ".retry"},    32'(retry_count),  32'(m_retry));
        chk({tag, ".loss"},     32'(lock_loss_count), 32'(m_loss));
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_74a);
            if (reset_n) model_step(pll_locked_async, relock_req);
            @(negedge clk_74a);
            check_outputs("cyc");
            relock_req = 1'b0;
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, ".core_rn"}, 32'(core_reset_n), 32'd0);
        chk({tag, ".ready"},   32'(pll_ready), 32'd0);
        chk({tag, ".fail"},    32'(fail), 32'd0);
        chk({tag, ".retry"},   32'(retry_count), 32'd0);
        chk({tag, ".loss"},    32'(lock_loss_count), 32'd0);
        @(negedge clk_74a);
        check_outputs(tag);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit lock;
        bit relock;
        int n;
        bit e_prst;
        bit e_crn;
        bit e_rdy;
        bit e_fail;
        int e_retry;
        int e_loss;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int hold;

        // Timeout x3 -> FAIL at 108, relock, lock acquire, RUN at 132, loss at 135
        tbl[0]  = '{0, 0, 3,  1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 31, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1,  1, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 4,  0, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 36, 0, 0, 0, 0, 2, 0};
        tbl[6]  = '{0, 0, 31, 0, 0, 0, 0, 2, 0};
        tbl[7]  = '{0, 0, 1,  1, 0, 0, 1, 2, 0};
        tbl[8]  = '{0, 0, 10, 1, 0, 0, 1, 2, 0};
        tbl[9]  = '{0, 1, 1,  1, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 4,  0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 8,  0, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 1,  0, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 2,  0, 1, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 1,  1, 0, 0, 0, 0, LOSS_EN};

        reset_n          = 1'b0;
        pll_locked_async = 1'b0;
        relock_req       = 1'b0;
        model_reset();
        @(negedge clk_74a);
        @(negedge clk_74a);
        chk("reset.pll_rst", 32'(pll_rst), 32'd1);
        chk("reset.core_rn", 32'(core_reset_n), 32'd0);
        check_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            pll_locked_async = tbl[i].lock;
            relock_req       = tbl[i].relock;
            cyc(tbl[i].n);
            chk($sformatf("vec%0d.pll_rst", i), 32'(pll_rst),      32'(tbl[i].e_prst));
            chk($sformatf("vec%0d.core_rn", i), 32'(core_reset_n), 32'(tbl[i].e_crn));
            chk($sformatf("vec%0d.ready", i),   32'(pll_ready),    32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.fail", i),    32'(fail),         32'(tbl[i].e_fail));
            chk($sformatf("vec%0d.retry", i),   32'(retry_count),  32'(tbl[i].e_retry));
            chk($sformatf("vec%0d.loss", i),    32'(lock_loss_count), 32'(tbl[i].e_loss));
        end

        // Lock from first WAIT_LOCK edge: release 11 edges after entry; relock in WAIT ignored
        async_reset_check("rst_a");
        pll_locked_async = 1'b0;
        cyc(4);
        pll_locked_async = 1'b1;
        relock_req       = 1'b1;
        cyc(1);
        chk("relock_wait_ign", 32'(pll_rst), 32'd0);
        cyc(9);
        chk("lock11_before", 32'(core_reset_n), 32'd0);
        cyc(1);
        chk("lock11_at", 32'(core_reset_n), 32'd1);

        // Relock in RUN: pll_rst next edge, no loss counted
        relock_req = 1'b1;
        cyc(1);
        chk("relock_run_prst", 32'(pll_rst), 32'd1);
        chk("relock_run_loss", 32'(lock_loss_count), 32'd0);

        // One-cycle glitch at stable count 5; drop coincides with count completion
        cyc(4);
        cyc(1);
        chk("glitch_in_stable", 32'(pll_rst), 32'd0);
        cyc(5);
        pll_locked_async = 1'b0;
        cyc(1);
        pll_locked_async = 1'b1;
        cyc(2);
        chk("glitch_crn_low", 32'(core_reset_n), 32'd0);
        chk("glitch_retry", 32'(retry_count), 32'd0);
        cyc(8);
        chk("glitch_crn_late", 32'(core_reset_n), 32'd0);
        cyc(1);
        chk("glitch_crn_run", 32'(core_reset_n), 32'd1);

        // Asynchronous reset mid-RUN, then mid-STABLE
        async_reset_check("rst_run");
        cyc(7);
        async_reset_check("rst_stable");

        // Lock-loss counter saturation
        for (int j = 0; j < 260; j++) begin
            pll_locked_async = 1'b1;
            w = 0;
            while (!pll_ready && w < 100) begin
                cyc(1);
                w++;
            end
            chk("sat_reach_run", 32'(pll_ready), 32'd1);
            pll_locked_async = 1'b0;
            cyc(3);
        end
        chk("loss_sat", 32'(lock_loss_count), (LOSS_EN != 0) ? 32'd255 : 32'd0);

        // Randomised traffic against the model
        async_reset_check("rst_rnd0");
        hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                pll_locked_async = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 80));
            end
            hold--;
            relock_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 999) == 0) begin
                async_reset_check("rst_rnd");
            end
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
